// File: rtl/sync_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sync_fifo_pkg
// Shared constants and helpers for the sync_fifo block:
//   DEF_WIDTH / DEF_DEPTH : default data width and storage depth
//   ptr_w()               : pointer width for a given depth (at least 1 bit)
//   ptr_inc()             : pointer increment that wraps DEPTH-1 -> 0
// ---------------------------------------------------------------------------
package sync_fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned ptr_inc(input int unsigned ptr,
                                            input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// ---------------------------------------------------------------------------
// sync_fifo_mem
// DEPTH x WIDTH register array with one write port and one synchronous,
// registered read port. Storage is never cleared; only the read register is.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (clears rdata only)
//   we    : write enable, waddr : write address, wdata : write data
//   re    : read enable,  raddr : read address,  rdata : registered read data
//           (holds its value when re is low)
// ---------------------------------------------------------------------------
module sync_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with write-enable / read-enable handshake and a
// one-cycle registered read. Full and empty are told apart by an occupancy
// counter, so the pointers are plain DEPTH-modulo indices.
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   wr_en    : write request      wr_data  : write data
//   full     : no free entry (registered)
//   rd_en    : read request
//   rd_data  : registered read data, holds when no read is accepted
//   rd_valid : rd_data carries a word popped in the previous cycle
//   empty    : no stored entry (registered)
//   count    : stored entries, 0..DEPTH
// Optional (macro SYNC_FIFO_ERR_FLAGS_EN):
//   overflow  : sticky, set the cycle after wr_en while full
//   underflow : sticky, set the cycle after rd_en while empty
// ---------------------------------------------------------------------------
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             empty,
    output logic [AW:0]      count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_acc;
    logic          rd_acc;
    logic [AW:0]   count_nxt;

    // Requests against a full/empty FIFO are dropped here, so nothing
    // downstream ever sees an illegal access.
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_comb begin
        count_nxt = count;
        if (wr_acc && !rd_acc) begin
            count_nxt = count + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= AW'(ptr_inc(32'(wr_ptr), $unsigned(DEPTH)));
            end
            if (rd_acc) begin
                rd_ptr <= AW'(ptr_inc(32'(rd_ptr), $unsigned(DEPTH)));
            end
            count    <= count_nxt;
            // Flags come from the next count so they are valid in the same
            // cycle as the updated count.
            full     <= (count_nxt == (AW+1)'(DEPTH));
            empty    <= (count_nxt == '0);
            rd_valid <= rd_acc;
        end
    end

    // Accesses in the reset cycle are suppressed so reset discards them.
    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc & ~rst),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .re    (rd_acc & ~rst),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule
